// File: rtl/cov_pkg.sv
// rtl/cov_pkg.sv - shared types, index tables and helpers for covariance_block.
// Optional feature macro: COV_MEAN_REMOVAL_EN.
package cov_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINAL,
        ST_DONE
    } cov_state_t;

    localparam int NUM_CH      = 4;
    localparam int NUM_ENTRIES = 10;

    function automatic int s_width(input int log2n);
        return 16 + log2n;
    endfunction

    function automatic int p_width(input int log2n);
        return 32 + log2n;
    endfunction

    // Upper-triangle walk: (1,1),(1,2),(1,3),(1,4),(2,2),(2,3),(2,4),(3,3),(3,4),(4,4)
    function automatic logic [1:0] entry_i(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2, 4'd3: return 2'd0;
            4'd4, 4'd5, 4'd6:       return 2'd1;
            4'd7, 4'd8:             return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] entry_j(input logic [3:0] k);
        case (k)
            4'd0:                   return 2'd0;
            4'd1, 4'd4:             return 2'd1;
            4'd2, 4'd5, 4'd7:       return 2'd2;
            default:                return 2'd3;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'sh7FFF;
        else if (v < -33'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/cov_entry_calc.sv
// rtl/cov_entry_calc.sv - one covariance entry: scale, optional mean removal, shift, saturate.
// Optional feature macro: COV_MEAN_REMOVAL_EN.
import cov_pkg::*;

module cov_entry_calc #(
    parameter int LOG2N     = 10,
    parameter int OUT_SHIFT = 8
) (
    input  logic signed [32+LOG2N-1:0] p_ij,
    input  logic signed [15:0]         m_i,
    input  logic signed [15:0]         m_j,
    output logic signed [15:0]         entry
);

    localparam int PW = p_width(LOG2N);

    logic signed [PW-1:0] p_sh;
    logic signed [32:0]   p_scaled;
    logic signed [31:0]   mm;
    logic signed [32:0]   e;
    logic signed [32:0]   e_sh;

    // The mean of 32-bit products always fits in 32 bits, so the low 33 bits are exact.
    assign p_sh     = p_ij >>> LOG2N;
    assign p_scaled = p_sh[32:0];
    assign mm       = 32'(m_i) * 32'(m_j);

`ifdef COV_MEAN_REMOVAL_EN
    assign e = p_scaled - 33'(mm);
`else
    logic unused_mm;
    assign unused_mm = ^mm;
    assign e = p_scaled;
`endif

    assign e_sh  = e >>> OUT_SHIFT;
    assign entry = sat16(e_sh);

endmodule

// File: rtl/covariance_block.sv
// rtl/covariance_block.sv - streaming 4-channel covariance matrix and channel means.
// Optional feature macro: COV_MEAN_REMOVAL_EN (mean subtraction and M1..M4 outputs).
import cov_pkg::*;

module covariance_block #(
    parameter int LOG2N     = 10,
    parameter int OUT_SHIFT = 8
) (
    input  logic        CLK_covariance,
    input  logic        RST_covariance,
    input  logic        GO_covariance,
    input  logic        New_one,
    input  logic [15:0] X1,
    input  logic [15:0] X2,
    input  logic [15:0] X3,
    input  logic [15:0] X4,
    input  logic        X_valid,
    output logic        X_ready,
    output logic        Covariance_busy,
    output logic        C_valid,
    output logic [15:0] C11, C12, C13, C14,
    output logic [15:0] C21, C22, C23, C24,
    output logic [15:0] C31, C32, C33, C34,
    output logic [15:0] C41, C42, C43, C44,
    output logic [15:0] M1, M2, M3, M4
);

    localparam int SW = s_width(LOG2N);
    localparam int PW = p_width(LOG2N);

    cov_state_t              state;
    logic [LOG2N-1:0]        cnt;
    logic [3:0]              k;
    logic signed [15:0]      x       [NUM_CH];
    logic signed [15:0]      m       [NUM_CH];
    logic signed [31:0]      prod    [NUM_ENTRIES];
    logic signed [PW-1:0]    p       [NUM_ENTRIES];
    logic signed [15:0]      stage_c [NUM_ENTRIES];
    logic signed [15:0]      c_reg   [NUM_ENTRIES];
    logic signed [PW-1:0]    p_sel;
    logic signed [15:0]      m_i_sel;
    logic signed [15:0]      m_j_sel;
    logic signed [15:0]      entry;
    logic                    start;
    logic                    accept;

    assign x[0] = X1;
    assign x[1] = X2;
    assign x[2] = X3;
    assign x[3] = X4;

    assign start  = (state == ST_IDLE) && GO_covariance && !New_one;
    assign accept = (state == ST_ACCUM) && X_valid && X_ready && !New_one;

    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++)
            prod[e] = 32'(x[entry_i(4'(e))]) * 32'(x[entry_j(4'(e))]);
    end

    always_comb begin
        p_sel   = p[k];
        m_i_sel = m[entry_i(k)];
        m_j_sel = m[entry_j(k)];
    end

    cov_entry_calc #(
        .LOG2N     (LOG2N),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_entry_calc (
        .p_ij  (p_sel),
        .m_i   (m_i_sel),
        .m_j   (m_j_sel),
        .entry (entry)
    );

`ifdef COV_MEAN_REMOVAL_EN
    logic signed [SW-1:0] s     [NUM_CH];
    logic signed [15:0]   m_reg [NUM_CH];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            m[c] = s[c][LOG2N +: 16];
    end

    // S stays frozen through FINAL/DONE, so it doubles as the staging for the means.
    always_ff @(posedge CLK_covariance) begin
        if (RST_covariance) begin
            for (int c = 0; c < NUM_CH; c++) begin
                s[c]     <= '0;
                m_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (start)
                    s[c] <= '0;
                else if (accept)
                    s[c] <= s[c] + {{LOG2N{x[c][15]}}, x[c]};
                if (state == ST_DONE && !New_one)
                    m_reg[c] <= m[c];
            end
        end
    end

    assign M1 = m_reg[0];
    assign M2 = m_reg[1];
    assign M3 = m_reg[2];
    assign M4 = m_reg[3];
`else
    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            m[c] = '0;
    end

    assign M1 = '0;
    assign M2 = '0;
    assign M3 = '0;
    assign M4 = '0;
`endif

    always_ff @(posedge CLK_covariance) begin
        if (RST_covariance) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            k               <= '0;
            X_ready         <= 1'b0;
            Covariance_busy <= 1'b0;
            C_valid         <= 1'b0;
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                p[e]       <= '0;
                stage_c[e] <= '0;
                c_reg[e]   <= '0;
            end
        end else if (New_one) begin
            state           <= ST_IDLE;
            X_ready         <= 1'b0;
            Covariance_busy <= 1'b0;
            C_valid         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    C_valid <= 1'b0;
                    if (GO_covariance) begin
                        state           <= ST_ACCUM;
                        cnt             <= '0;
                        X_ready         <= 1'b1;
                        Covariance_busy <= 1'b1;
                        for (int e = 0; e < NUM_ENTRIES; e++)
                            p[e] <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        for (int e = 0; e < NUM_ENTRIES; e++)
                            p[e] <= p[e] + {{LOG2N{prod[e][31]}}, prod[e]};
                        cnt <= cnt + 1'b1;
                        if (&cnt) begin
                            state   <= ST_FINAL;
                            X_ready <= 1'b0;
                            k       <= '0;
                        end
                    end
                end
                ST_FINAL: begin
                    stage_c[k] <= entry;
                    if (k == 4'(NUM_ENTRIES - 1))
                        state <= ST_DONE;
                    else
                        k <= k + 1'b1;
                end
                ST_DONE: begin
                    for (int e = 0; e < NUM_ENTRIES; e++)
                        c_reg[e] <= stage_c[e];
                    C_valid         <= 1'b1;
                    Covariance_busy <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign C11 = c_reg[0];
    assign C12 = c_reg[1];
    assign C13 = c_reg[2];
    assign C14 = c_reg[3];
    assign C21 = c_reg[1];
    assign C22 = c_reg[4];
    assign C23 = c_reg[5];
    assign C24 = c_reg[6];
    assign C31 = c_reg[2];
    assign C32 = c_reg[5];
    assign C33 = c_reg[7];
    assign C34 = c_reg[8];
    assign C41 = c_reg[3];
    assign C42 = c_reg[6];
    assign C43 = c_reg[8];
    assign C44 = c_reg[9];

endmodule

// File: tb/tb_covariance_block.sv
// tb/tb_covariance_block.sv - directed self-checking bench for covariance_block (LOG2N=2, OUT_SHIFT=8).
module tb_covariance_block;

    localparam int LOG2N     = 2;
    localparam int OUT_SHIFT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, go, new_one, x_valid;
    logic [15:0] x1, x2, x3, x4;
    logic        x_ready, busy, c_valid;
    logic [15:0] c11, c12, c13, c14, c21, c22, c23, c24;
    logic [15:0] c31, c32, c33, c34, c41, c42, c43, c44;
    logic [15:0] m1, m2, m3, m4;

    covariance_block #(.LOG2N(LOG2N), .OUT_SHIFT(OUT_SHIFT)) dut (
        .CLK_covariance  (clk),
        .RST_covariance  (rst),
        .GO_covariance   (go),
        .New_one         (new_one),
        .X1 (x1), .X2 (x2), .X3 (x3), .X4 (x4),
        .X_valid         (x_valid),
        .X_ready         (x_ready),
        .Covariance_busy (busy),
        .C_valid         (c_valid),
        .C11 (c11), .C12 (c12), .C13 (c13), .C14 (c14),
        .C21 (c21), .C22 (c22), .C23 (c23), .C24 (c24),
        .C31 (c31), .C32 (c32), .C33 (c33), .C34 (c34),
        .C41 (c41), .C42 (c42), .C43 (c43), .C44 (c44),
        .M1 (m1), .M2 (m2), .M3 (m3), .M4 (m4)
    );

    logic signed [15:0] c_obs [16];
    logic signed [15:0] m_obs [4];
    assign c_obs = '{c11, c12, c13, c14, c21, c22, c23, c24,
                     c31, c32, c33, c34, c41, c42, c43, c44};
    assign m_obs = '{m1, m2, m3, m4};

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int exp_c [16];
    int exp_m [4];
    logic signed [15:0] smp [4][4];

    always @(negedge clk) if (c_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // x1 = +a (alternating sign when alt), x2 = s2*x1, x3 = x4 = 0
    task automatic set_smp(input int a, input bit alt, input int s2);
        for (int n = 0; n < 4; n++) begin
            smp[n][0] = 16'((alt && n % 2 == 1) ? -a : a);
            smp[n][1] = 16'(s2 * int'(smp[n][0]));
            smp[n][2] = '0;
            smp[n][3] = '0;
        end
    endtask

    task automatic set_exp(input int e11, input int e12, input int e22, input int em1);
        for (int i = 0; i < 16; i++) exp_c[i] = 0;
        for (int i = 0; i < 4; i++)  exp_m[i] = 0;
        exp_c[0] = e11;
        exp_c[1] = e12;
        exp_c[4] = e12;
        exp_c[5] = e22;
        exp_m[0] = em1;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s C%0d%0d", tag, i / 4 + 1, i % 4 + 1), c_obs[i], exp_c[i]);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s M%0d", tag, i + 1), m_obs[i], exp_m[i]);
    endtask

    task automatic feed(input int n, input int gap);
        for (int g = 0; g < gap; g++) begin
            x_valid = 1'b0;
            step();
        end
        x1 = smp[n][0]; x2 = smp[n][1]; x3 = smp[n][2]; x4 = smp[n][3];
        x_valid = 1'b1;
        step();
        x_valid = 1'b0;
    endtask

    task automatic frame(input string tag, input int gap, input bit go_in_final);
        int lat;
        int p0;
        go = 1'b1;
        step();
        go = 1'b0;
        check({tag, " busy_start"}, busy, 1);
        check({tag, " ready_start"}, x_ready, 1);
        for (int n = 0; n < 4; n++) feed(n, gap);
        check({tag, " ready_drop"}, x_ready, 0);
        p0  = pulses;
        lat = 0;
        while (c_valid !== 1'b1 && lat < 40) begin
            go = (go_in_final && lat == 3);
            step();
            lat++;
        end
        go = 1'b0;
        check({tag, " c_valid_latency"}, lat, 11);
        step();
        check({tag, " c_valid_pulse_end"}, c_valid, 0);
        check({tag, " pulse_count"}, pulses - p0, 1);
        check({tag, " busy_end"}, busy, 0);
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; new_one = 1'b0; x_valid = 1'b0;
        x1 = '0; x2 = '0; x3 = '0; x4 = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset ready", x_ready, 0);
        check("reset busy", busy, 0);
        check("reset c_valid", c_valid, 0);
        set_exp(0, 0, 0, 0);
        check_all("reset");

        set_smp(100, 1'b0, 0);
`ifdef COV_MEAN_REMOVAL_EN
        set_exp(0, 0, 0, 100);
`else
        set_exp(39, 0, 0, 0);
`endif
        frame("const", 0, 1'b0);

        set_smp(256, 1'b1, 0);
        set_exp(256, 0, 0, 0);
        frame("pm256", 0, 1'b0);
        frame("throttle", 3, 1'b0);

        set_smp(256, 1'b1, 1);
        set_exp(256, 256, 256, 0);
        frame("corr_pos", 0, 1'b0);

        set_smp(256, 1'b1, -1);
        set_exp(256, -256, 256, 0);
        frame("corr_neg_go_final", 0, 1'b1);
        check("go_final ignored busy", busy, 0);

        set_smp(32767, 1'b1, -1);
        set_exp(32767, -32768, 32767, 0);
        frame("sat", 0, 1'b0);

        set_smp(256, 1'b1, 0);
        set_exp(256, 0, 0, 0);
        frame("baseline", 0, 1'b0);

        begin
            int p0;
            p0 = pulses;
            go = 1'b1;
            step();
            go = 1'b0;
            feed(0, 0);
            feed(1, 0);
            new_one = 1'b1;
            step();
            new_one = 1'b0;
            check("abort busy", busy, 0);
            check("abort ready", x_ready, 0);
            repeat (20) step();
            check("abort no c_valid", pulses - p0, 0);
            check_all("abort");

            go = 1'b1; new_one = 1'b1;
            step();
            go = 1'b0; new_one = 1'b0;
            check("new_one_wins busy", busy, 0);
            check("new_one_wins ready", x_ready, 0);
        end

        go = 1'b1;
        step();
        go = 1'b0;
        feed(0, 0);
        feed(1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midreset ready", x_ready, 0);
        check("midreset busy", busy, 0);
        set_exp(0, 0, 0, 0);
        check_all("midreset");

        set_smp(256, 1'b1, 0);
        set_exp(256, 0, 0, 0);
        frame("clean", 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
